spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 114 +++++++++++
 tb/tb_spi_flash_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-requester SPI flash arbiter. A registered one-hot grant muxes the granted
// requester onto the shared flash, and a guard gap separates consecutive grants.
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_ss,
    input  logic [1:0] req_sck,
    input  logic [1:0] req_mosi,
    output logic [1:0] req_miso,
    output logic [1:0] gnt,
    output logic       flash_ss,
    output logic       flash_sck,
    output logic       flash_mosi,
    input  logic       flash_miso
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GUARD  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    state_t             arb_pick;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_gnt;
    logic               last_gnt_nxt;
    logic [1:0]         gnt_nxt;

    // State, guard counter, fairness bit and grant register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            gnt      <= 2'b00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_gnt <= last_gnt_nxt;
            gnt      <= gnt_nxt;
        end
    end

    // Next-state logic; a tie goes to the requester not served last
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_gnt_nxt = last_gnt;
        arb_pick     = IDLE;

        if (!req_ss[0] && !req_ss[1]) begin
            arb_pick = last_gnt ? GRANT0 : GRANT1;
        end else if (!req_ss[0]) begin
            arb_pick = GRANT0;
        end else if (!req_ss[1]) begin
            arb_pick = GRANT1;
        end

        case (state)
            IDLE: state_nxt = arb_pick;
            GRANT0: begin
                if (req_ss[0]) begin
                    state_nxt    = GUARD;
                    cnt_nxt      = CNT_W'(GUARD_CYCLES - 1);
                    last_gnt_nxt = 1'b0;
                end
            end
            GRANT1: begin
                if (req_ss[1]) begin
                    state_nxt    = GUARD;
                    cnt_nxt      = CNT_W'(GUARD_CYCLES - 1);
                    last_gnt_nxt = 1'b1;
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    state_nxt = arb_pick;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        gnt_nxt = {state_nxt == GRANT1, state_nxt == GRANT0};
    end

    // Flash mux driven only by the registered grant
    always_comb begin
        flash_ss   = 1'b1;
        flash_sck  = 1'b0;
        flash_mosi = 1'b0;
        if (gnt[0]) begin
            flash_ss   = req_ss[0];
            flash_sck  = req_sck[0];
            flash_mosi = req_mosi[0];
        end else if (gnt[1]) begin
            flash_ss   = req_ss[1];
            flash_sck  = req_sck[1];
            flash_mosi = req_mosi[1];
        end
    end

    assign req_miso = gnt & {2{flash_miso}};

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: grant latency, mux, guard gap,
// tie-break, withdrawn request, async reset and alternation.
module tb_spi_flash_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_ss;
    logic [1:0] req_sck;
    logic [1:0] req_mosi;
    logic [1:0] req_miso;
    logic [1:0] gnt;
    logic       flash_ss;
    logic       flash_sck;
    logic       flash_mosi;
    logic       flash_miso;

    int total = 0;
    int bad   = 0;
    int gap;

    spi_flash_arbiter #(.GUARD_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_ss     (req_ss),
        .req_sck    (req_sck),
        .req_mosi   (req_mosi),
        .req_miso   (req_miso),
        .gnt        (gnt),
        .flash_ss   (flash_ss),
        .flash_sck  (flash_sck),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts idle cycles until a grant appears, checking the flash stays deselected
    task automatic wait_grant(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("onehot", 4'(gnt != 2'b11), 4'd1);
            if (gnt != 2'b00) break;
            n++;
            chk("guard_ss_high", 4'(flash_ss), 4'd1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_ss     = 2'b11;
        req_sck    = 2'b00;
        req_mosi   = 2'b00;
        flash_miso = 1'b0;
        step(2);

        // Reset state
        chk("rst_gnt", 4'(gnt), 4'h0);
        chk("rst_ss", 4'(flash_ss), 4'h1);
        chk("rst_sck", 4'(flash_sck), 4'h0);
        chk("rst_miso", 4'(req_miso), 4'h0);
        rst = 1'b0;
        step(2);

        // Single request from requester 0: one-cycle latency, mux and isolation
        req_ss = 2'b10;
        step(1);
        chk("single_gnt", 4'(gnt), 4'h1);
        chk("single_ss", 4'(flash_ss), 4'h0);
        req_sck = 2'b10;
        req_mosi = 2'b10;
        #1;
        chk("single_sck_iso", 4'(flash_sck), 4'h0);
        chk("single_mosi_iso", 4'(flash_mosi), 4'h0);
        req_sck = 2'b01;
        req_mosi = 2'b01;
        flash_miso = 1'b1;
        #1;
        chk("single_sck", 4'(flash_sck), 4'h1);
        chk("single_mosi", 4'(flash_mosi), 4'h1);
        chk("single_miso", 4'(req_miso), 4'h1);
        step(1);
        req_sck = 2'b00;
        req_mosi = 2'b00;
        flash_miso = 1'b0;
        req_ss = 2'b11;
        step(1);
        chk("rel_gnt", 4'(gnt), 4'h0);
        chk("rel_ss", 4'(flash_ss), 4'h1);
        step(4);
        chk("idle_gnt", 4'(gnt), 4'h0);

        // Tie right after reset goes to requester 0, then guard, then requester 1
        do_reset();
        req_ss = 2'b00;
        step(1);
        chk("tie_gnt", 4'(gnt), 4'h1);
        step(2);
        req_ss = 2'b01;
        wait_grant(gap);
        chk("tie_gap", 4'(gap), 4'd2);
        chk("tie_gnt1", 4'(gnt), 4'h2);

        // Requester 1 releases and re-requests at once: guard still enforced
        step(2);
        req_ss = 2'b11;
        step(1);
        req_ss = 2'b01;
        wait_grant(gap);
        chk("rereq_gap", 4'(gap + 1), 4'd2);
        chk("rereq_gnt", 4'(gnt), 4'h2);

        // Back to idle, then a request from 1 withdrawn during requester 0's grant
        req_ss = 2'b11;
        step(4);
        req_ss = 2'b10;
        step(1);
        chk("wd_gnt0", 4'(gnt), 4'h1);
        req_ss = 2'b00;
        step(1);
        req_ss = 2'b10;
        step(1);
        req_ss = 2'b11;
        wait_grant(gap);
        chk("wd_no_gnt", 4'(gnt), 4'h0);
        chk("wd_gap", 4'(gap), 4'd10);

        // Reset mid-transfer while requester 1 holds the flash
        req_ss = 2'b01;
        step(1);
        chk("mr_gnt1", 4'(gnt), 4'h2);
        chk("mr_ss_low", 4'(flash_ss), 4'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_ss_async", 4'(flash_ss), 4'h1);
        chk("mr_gnt_async", 4'(gnt), 4'h0);
        step(2);
        req_ss = 2'b00;
        rst = 1'b0;
        step(1);
        chk("mr_tie_gnt", 4'(gnt), 4'h1);

        // Continuous requests from both: strict alternation with guard gaps
        for (int k = 0; k < 6; k++) begin
            chk("alt_gnt", 4'(gnt), (k % 2 == 0) ? 4'h1 : 4'h2);
            step(2);
            chk("alt_hold", 4'(gnt), (k % 2 == 0) ? 4'h1 : 4'h2);
            req_ss = (k % 2 == 0) ? 2'b01 : 2'b10;
            step(1);
            chk("alt_guard_gnt", 4'(gnt), 4'h0);
            chk("alt_guard_ss", 4'(flash_ss), 4'h1);
            req_ss = 2'b00;
            wait_grant(gap);
            chk("alt_gap", 4'(gap + 1), 4'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
